// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: producer results, flush/enable controls and the broadcast.
interface cdb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic              rdy;
  logic              in_rob_clear;
  logic [TAG_W-1:0]  in_alu_reorder;
  logic [DATA_W-1:0] in_alu_value;
  logic [TAG_W-1:0]  in_lsb_reorder;
  logic [DATA_W-1:0] in_lsb_value;
  logic [TAG_W-1:0]  in_br_reorder;
  logic [DATA_W-1:0] in_br_value;
  logic              out_alu_full;
  logic              out_lsb_full;
  logic              out_br_full;
  logic [TAG_W-1:0]  out_cdb_reorder;
  logic [DATA_W-1:0] out_cdb_value;
  logic [1:0]        out_cdb_src;
  logic              out_overflow;

  // Producer / consumer side
  modport master (
    output rdy, in_rob_clear,
    output in_alu_reorder, in_alu_value, in_lsb_reorder, in_lsb_value,
    output in_br_reorder, in_br_value,
    input  out_alu_full, out_lsb_full, out_br_full,
    input  out_cdb_reorder, out_cdb_value, out_cdb_src, out_overflow
  );

  // Arbiter side
  modport slave (
    input  rdy, in_rob_clear,
    input  in_alu_reorder, in_alu_value, in_lsb_reorder, in_lsb_value,
    input  in_br_reorder, in_br_value,
    output out_alu_full, out_lsb_full, out_br_full,
    output out_cdb_reorder, out_cdb_value, out_cdb_src, out_overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: per-source FIFOs (ALU=0, LSB=1, BR=2) feeding one
// registered broadcast per cycle.
// Optional feature: define CDB_BYPASS_EN to let an empty source's live input
// be granted directly in the cycle it arrives.
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned NSRC  = 3;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SRC_W = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [TAG_W-1:0]  mem_tag [NSRC][DEPTH];
  logic [DATA_W-1:0] mem_val [NSRC][DEPTH];

  logic [PTR_W-1:0]  head_q [NSRC];
  logic [PTR_W-1:0]  head_d [NSRC];
  logic [PTR_W-1:0]  tail_q [NSRC];
  logic [PTR_W-1:0]  tail_d [NSRC];
  logic [CNT_W-1:0]  cnt_q  [NSRC];
  logic [CNT_W-1:0]  cnt_d  [NSRC];
  logic [SRC_W-1:0]  last_q, last_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic              ovf_q, ovf_d;

  logic [TAG_W-1:0]  in_tag [NSRC];
  logic [DATA_W-1:0] in_val [NSRC];
  logic [NSRC-1:0]   cand, byp, pop, we, push;
  logic              found;
  logic [SRC_W-1:0]  gnt, sel;

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NSRC - 1)) ? '0 : s + SRC_W'(1);
  endfunction

  // Gather per-source inputs into indexable arrays
  always_comb begin
    in_tag[0] = bus.in_alu_reorder;
    in_val[0] = bus.in_alu_value;
    in_tag[1] = bus.in_lsb_reorder;
    in_val[1] = bus.in_lsb_value;
    in_tag[2] = bus.in_br_reorder;
    in_val[2] = bus.in_br_value;
  end

  // Grant selection, queue pointer/count update and broadcast next-state
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    cdb_tag_d = cdb_tag_q;
    cdb_val_d = cdb_val_q;
    cdb_src_d = cdb_src_q;
    ovf_d     = ovf_q;
    cand      = '0;
    byp       = '0;
    pop       = '0;
    we        = '0;
    push      = '0;
    found     = 1'b0;
    gnt       = '0;
    sel       = last_q;

    if (bus.rdy) begin
      if (bus.in_rob_clear) begin
        for (int s = 0; s < NSRC; s++) begin
          head_d[s] = '0;
          tail_d[s] = '0;
          cnt_d[s]  = '0;
        end
        cdb_tag_d = '0;
      end else begin
        for (int s = 0; s < NSRC; s++) begin
          if (cnt_q[s] != '0) begin
            cand[s] = 1'b1;
          end else if (BYPASS && (in_tag[s] != '0)) begin
            cand[s] = 1'b1;
            byp[s]  = 1'b1;
          end
        end

        // Search last+1, last+2, last
        for (int k = 0; k < NSRC; k++) begin
          sel = next_src(sel);
          if (!found && cand[sel]) begin
            found = 1'b1;
            gnt   = sel;
          end
        end

        if (found) begin
          last_d    = gnt;
          cdb_src_d = gnt;
        end else begin
          cdb_tag_d = '0;
        end

        for (int s = 0; s < NSRC; s++) begin
          if (found && (gnt == SRC_W'(s))) begin
            if (byp[s]) begin
              cdb_tag_d = in_tag[s];
              cdb_val_d = in_val[s];
            end else begin
              cdb_tag_d = mem_tag[s][head_q[s]];
              cdb_val_d = mem_val[s][head_q[s]];
              pop[s]    = 1'b1;
            end
          end
          push[s] = (in_tag[s] != '0) && !(found && byp[s] && (gnt == SRC_W'(s)));
          if (push[s]) begin
            if ((cnt_q[s] != CNT_W'(DEPTH)) || pop[s]) begin
              we[s] = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (pop[s]) begin
            head_d[s] = head_q[s] + PTR_W'(1);
          end
          if (we[s]) begin
            tail_d[s] = tail_q[s] + PTR_W'(1);
          end
          cnt_d[s] = cnt_q[s] + CNT_W'(we[s]) - CNT_W'(pop[s]);
        end
      end
    end
  end

  // Queue storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      if (we[s]) begin
        mem_tag[s][tail_q[s]] <= in_tag[s];
        mem_val[s][tail_q[s]] <= in_val[s];
      end
    end
  end

  // State and broadcast registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSRC; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q    <= SRC_W'(NSRC - 1);
      cdb_tag_q <= '0;
      cdb_val_q <= '0;
      cdb_src_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      cdb_tag_q <= cdb_tag_d;
      cdb_val_q <= cdb_val_d;
      cdb_src_q <= cdb_src_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.out_alu_full    = (cnt_q[0] == CNT_W'(DEPTH));
  assign bus.out_lsb_full    = (cnt_q[1] == CNT_W'(DEPTH));
  assign bus.out_br_full     = (cnt_q[2] == CNT_W'(DEPTH));
  assign bus.out_cdb_reorder = cdb_tag_q;
  assign bus.out_cdb_value   = cdb_val_q;
  assign bus.out_cdb_src     = cdb_src_q;
  assign bus.out_overflow    = ovf_q;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB). Three execution sources (ALU, load/store buffer, branch unit) each present at most one finished result per cycle, tagged with its ROB reorder tag. The block buffers each source in a small per-source queue and grants exactly one result per cycle onto the single registered CDB broadcast. The ROB and reservation stations consume that broadcast as their update value/reorder pair.

## Interface
Parameters:
- DATA_W, 32, result value width
- TAG_W, 4, ROB reorder tag width; tag 0 means no result
- DEPTH, 2, entries per source queue (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- rdy  in  1  global enable; when 0, all state holds
- in_rob_clear  in  1  flush (mispredict)
- in_alu_reorder  in  TAG_W  ALU result tag, 0 = none
- in_alu_value  in  DATA_W  ALU result value
- in_lsb_reorder  in  TAG_W  LSB result tag, 0 = none
- in_lsb_value  in  DATA_W  LSB result value
- in_br_reorder  in  TAG_W  branch-unit result tag, 0 = none
- in_br_value  in  DATA_W  branch-unit result value
- out_alu_full  out  1  ALU queue holds DEPTH entries (combinational from count)
- out_lsb_full  out  1  LSB queue full
- out_br_full  out  1  branch queue full
- out_cdb_reorder  out  TAG_W  broadcast tag, 0 = idle (registered)
- out_cdb_value  out  DATA_W  broadcast value (registered)
- out_cdb_src  out  2  granted source: 0 ALU, 1 LSB, 2 BR (registered)
- out_overflow  out  1  sticky: a result was dropped

## Operation
- Source indices: ALU=0, LSB=1, BR=2. Each source has a circular FIFO: head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of 0..DEPTH.
- Enqueue: a nonzero in_x_reorder with rdy=1 and in_rob_clear=0 writes {tag, value} at the tail.
- Candidate per source: that source's queue head if count>0; otherwise none.
- Grant: a round-robin pointer `last` holds the last granted source. The search order is last+1, last+2, last (mod 3). The first candidate found is granted: its head is popped, and out_cdb_* is loaded with its tag/value/src. `last` is updated to that source.
- No candidate: out_cdb_reorder <= 0. out_cdb_value and out_cdb_src hold. `last` is unchanged.
- Full queue:
  - out_x_full=1 when count==DEPTH.
  - Producers must not present while full.
  - If one does and the same queue is popped that cycle, the arrival is accepted.
  - Otherwise the arrival is dropped and out_overflow <= 1.
  - out_overflow clears only on rst.
- Simultaneous push and pop on the same queue: count is unchanged and both pointers advance.
- Flush: in_rob_clear=1 with rdy=1 empties all queues (count/head/tail=0), discards that cycle's arrivals and sets out_cdb_reorder <= 0. `last` is unchanged. No grant that cycle.
- rdy=0: no enqueue, no grant, no flush; all registers and outputs hold.
- Reset: queues empty, last=2 (so ALU has first priority), out_cdb_reorder=0, out_cdb_value=0, out_cdb_src=0, out_overflow=0, all out_x_full=0.

## Timing
- Baseline latency: a result presented in cycle N is enqueued at edge N. It is earliest visible on out_cdb in cycle N+2 (after edge N+1).
- Throughput: one broadcast per cycle. With all three queues nonempty, grants rotate ALU, LSB, BR, ALU…
- out_cdb_reorder is nonzero for exactly one cycle per granted result (while rdy=1).
- Sustained input above the 1 result/cycle aggregate rate fills queues. Full flags assert combinationally in the cycle the count reaches DEPTH.

## Configuration
- CDB_BYPASS_EN defined:
  - A source with count==0 and a nonzero input this cycle offers that input as its candidate.
  - If granted, the input is driven to out_cdb at this edge and not enqueued (latency: visible cycle N+1).
  - If not granted, it is enqueued normally.
  - Flush and rdy=0 block bypass.
- CDB_BYPASS_EN undefined: only queue heads are candidates; latency as baseline.

## Test plan
- Reset, then ALU tag 3 value 0x11 in cycle 1 → out_cdb_reorder=3, value=0x11, src=0 in cycle 3 (in cycle 2 with CDB_BYPASS_EN); idle (tag 0) otherwise.
- Same cycle, ALU tag 1/0xA, LSB tag 2/0xB, BR tag 4/0xC → broadcasts tag 1, 2, 4 on consecutive cycles, src 0,1,2. Then next simultaneous set → order resumes from ALU.
- ALU presents tags 5,6,7 on three consecutive cycles while LSB/BR are continuously busy (DEPTH=2) → out_alu_full rises. Tag 7 arriving while full with no ALU pop → dropped, out_overflow=1 and stays 1.
- Queues hold 2 entries each, assert in_rob_clear for one cycle alongside new ALU tag 9 → next cycle out_cdb_reorder=0, all full flags 0, tag 9 never broadcast.
- Pending LSB tag 8, drop rdy for 4 cycles → outputs frozen; after rdy returns, tag 8 broadcast exactly once.
- Assert rst mid-stream with queues nonempty → next cycle all outputs at reset values; first post-reset grant favors ALU.
